// File: rtl/cpu_types_pkg.sv
// Shared ALU opcode types and FSM state encoding for alu_muldiv.
// aluop_t holds base ops; aluopx_t extends it with MULT/MULTU/DIV/DIVU.
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_SLL  = 4'h0,
      ALU_SRL  = 4'h1,
      ALU_ADD  = 4'h2,
      ALU_SUB  = 4'h3,
      ALU_AND  = 4'h4,
      ALU_OR   = 4'h5,
      ALU_XOR  = 4'h6,
      ALU_NOR  = 4'h7,
      ALU_SLT  = 4'h8,
      ALU_SLTU = 4'h9
   } aluop_t;

   typedef enum logic [4:0] {
      OPX_SLL   = 5'h00,
      OPX_SRL   = 5'h01,
      OPX_ADD   = 5'h02,
      OPX_SUB   = 5'h03,
      OPX_AND   = 5'h04,
      OPX_OR    = 5'h05,
      OPX_XOR   = 5'h06,
      OPX_NOR   = 5'h07,
      OPX_SLT   = 5'h08,
      OPX_SLTU  = 5'h09,
      OPX_MULT  = 5'h10,
      OPX_MULTU = 5'h11,
      OPX_DIV   = 5'h12,
      OPX_DIVU  = 5'h13
   } aluopx_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_DIV,
      S_DONE
   } md_state_t;

   function automatic logic is_md(input logic [4:0] op);
      return op[4:2] == 3'b100;
   endfunction

endpackage

// File: rtl/alu_md_iter.sv
// Iterative multiply (radix-2 shift-add) / restoring divide, one bit per cycle.
// Ports: CLK, nRST, start/op/a/b load, busy steps, last + res_lo/res_hi/ovf out.
module alu_md_iter
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             busy,
   output logic             last,
   output logic [WIDTH-1:0] res_lo,
   output logic [WIDTH-1:0] res_hi,
   output logic             ovf
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_CNT = SHW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   logic [WIDTH-1:0]   hi, lo, dv, a_keep;
   logic [SHW-1:0]     cnt;
   logic               is_div, neg_p, neg_r, dz, ovf_q;
   logic               sgn, a_neg, b_neg;
   logic [WIDTH:0]     addend, sum, sh, dif;
   logic [WIDTH-1:0]   nxt_hi, nxt_lo;
   logic [2*WIDTH-1:0] prod, prod_fix;

   assign sgn   = (op == OPX_MULT) || (op == OPX_DIV);
   assign a_neg = sgn & a[WIDTH-1];
   assign b_neg = sgn & b[WIDTH-1];
   assign last  = busy && (cnt == LAST_CNT);
   assign ovf   = ovf_q;

   // hi:lo is the product accumulator for multiply and the
   // remainder:dividend/quotient shift pair for divide.
   always_comb begin
      addend = {1'b0, (lo[0] ? dv : {WIDTH{1'b0}})};
      sum    = {1'b0, hi} + addend;
      sh     = {hi, lo[WIDTH-1]};
      dif    = sh - {1'b0, dv};
      if (is_div) begin
         nxt_hi = dif[WIDTH] ? sh[WIDTH-1:0] : dif[WIDTH-1:0];
         nxt_lo = {lo[WIDTH-2:0], ~dif[WIDTH]};
      end else begin
         nxt_hi = sum[WIDTH:1];
         nxt_lo = {sum[0], lo[WIDTH-1:1]};
      end
      prod     = {nxt_hi, nxt_lo};
      prod_fix = neg_p ? -prod : prod;
      res_lo   = prod_fix[WIDTH-1:0];
      res_hi   = prod_fix[2*WIDTH-1:WIDTH];
      if (is_div) begin
         if (dz) begin
            res_lo = {WIDTH{1'b1}};
            res_hi = a_keep;
         end else begin
            res_lo = neg_p ? -nxt_lo : nxt_lo;
            res_hi = neg_r ? -nxt_hi : nxt_hi;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hi     <= '0;
         lo     <= '0;
         dv     <= '0;
         a_keep <= '0;
         cnt    <= '0;
         is_div <= 1'b0;
         neg_p  <= 1'b0;
         neg_r  <= 1'b0;
         dz     <= 1'b0;
         ovf_q  <= 1'b0;
      end else if (start) begin
         hi     <= '0;
         lo     <= a_neg ? -a : a;
         dv     <= b_neg ? -b : b;
         a_keep <= a;
         cnt    <= '0;
         is_div <= op[1];
         neg_p  <= a_neg ^ b_neg;
         neg_r  <= a_neg;
         dz     <= (b == '0);
         ovf_q  <= (op == OPX_DIV) && (a == MIN_NEG) && (b == '1);
      end else if (busy) begin
         hi  <= nxt_hi;
         lo  <= nxt_lo;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// ALU with optional iterative MUL/DIV (enabled by macro ALU_MULDIV_EN).
// Ports: CLK, nRST, req_valid/req_ready, op, portA/B, resp_valid, results, flags.
module alu_muldiv
   import cpu_types_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int SHW   = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] portA,
   input  logic [WIDTH-1:0] portB,
   output logic             resp_valid,
   output logic [WIDTH-1:0] result_lo,
   output logic [WIDTH-1:0] result_hi,
   output logic             overflow,
   output logic             negative,
   output logic             zero
);

   md_state_t        state, nxt_state;
   logic             accept, md_op, md_last, md_ovf;
   logic [WIDTH-1:0] md_lo, md_hi;
   logic [WIDTH-1:0] base_lo, add_r, sub_r;
   logic             base_ovf;

   assign req_ready  = (state == S_IDLE) || (state == S_DONE);
   assign resp_valid = (state == S_DONE);
   assign accept     = req_valid && req_ready;
   assign negative   = result_lo[WIDTH-1];
   assign zero       = (result_lo == '0);

`ifdef ALU_MULDIV_EN
   assign md_op = is_md(op);

   alu_md_iter #(.WIDTH(WIDTH)) u_iter (
      .CLK    (CLK),
      .nRST   (nRST),
      .start  (accept && md_op),
      .op     (op),
      .a      (portA),
      .b      (portB),
      .busy   ((state == S_MUL) || (state == S_DIV)),
      .last   (md_last),
      .res_lo (md_lo),
      .res_hi (md_hi),
      .ovf    (md_ovf)
   );
`else
   assign md_op   = 1'b0;
   assign md_last = 1'b0;
   assign md_lo   = '0;
   assign md_hi   = '0;
   assign md_ovf  = 1'b0;
`endif

   always_comb begin
      add_r    = portA + portB;
      sub_r    = portA - portB;
      base_lo  = '0;
      base_ovf = 1'b0;
      unique case (1'b1)
         op == OPX_SLL:  base_lo = portA << portB[SHW-1:0];
         op == OPX_SRL:  base_lo = portA >> portB[SHW-1:0];
         op == OPX_ADD: begin
            base_lo  = add_r;
            base_ovf = (portA[WIDTH-1] == portB[WIDTH-1]) &&
                       (add_r[WIDTH-1] != portA[WIDTH-1]);
         end
         op == OPX_SUB: begin
            base_lo  = sub_r;
            base_ovf = (portA[WIDTH-1] != portB[WIDTH-1]) &&
                       (sub_r[WIDTH-1] != portA[WIDTH-1]);
         end
         op == OPX_AND:  base_lo = portA & portB;
         op == OPX_OR:   base_lo = portA | portB;
         op == OPX_XOR:  base_lo = portA ^ portB;
         op == OPX_NOR:  base_lo = ~(portA | portB);
         op == OPX_SLT:
            base_lo = {{(WIDTH-1){1'b0}}, $signed(portA) < $signed(portB)};
         op == OPX_SLTU:
            base_lo = {{(WIDTH-1){1'b0}}, portA < portB};
         default: base_lo = '0;
      endcase
   end

   always_comb begin
      nxt_state = state;
      unique case (state)
         S_IDLE, S_DONE: begin
            if (accept && md_op)
               nxt_state = op[1] ? S_DIV : S_MUL;
            else if (accept)
               nxt_state = S_DONE;
            else
               nxt_state = S_IDLE;
         end
         S_MUL, S_DIV: begin
            if (md_last)
               nxt_state = S_DONE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state     <= S_IDLE;
         result_lo <= '0;
         result_hi <= '0;
         overflow  <= 1'b0;
      end else begin
         state <= nxt_state;
         if (accept && !md_op) begin
            result_lo <= base_lo;
            result_hi <= '0;
            overflow  <= base_ovf;
         end else if (md_last) begin
            result_lo <= md_lo;
            result_hi <= md_hi;
            overflow  <= md_ovf;
         end
      end
   end

endmodule

// File: tb/tb_alu_muldiv.sv
// Self-checking bench for alu_muldiv: vector table, random ops vs model,
// back-to-back, reset-abort and an 8-bit multiply instance.
module tb_alu_muldiv;
   import cpu_types_pkg::*;

`ifdef ALU_MULDIV_EN
   localparam bit EN = 1'b1;
`else
   localparam bit EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        nrst = 1'b0;
   logic        rv = 1'b0;
   logic [4:0]  opv = 5'h0;
   logic [31:0] pa = '0, pb = '0;
   logic        ready, resp, ov, ng, zr;
   logic [31:0] lo, hi;

   logic        rv8 = 1'b0;
   logic [4:0]  op8 = 5'h0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        ready8, resp8, ov8, ng8, zr8;
   logic [7:0]  lo8, hi8;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   alu_muldiv #(.WIDTH(32)) dut (
      .CLK(clk), .nRST(nrst), .req_valid(rv), .req_ready(ready),
      .op(opv), .portA(pa), .portB(pb), .resp_valid(resp),
      .result_lo(lo), .result_hi(hi), .overflow(ov),
      .negative(ng), .zero(zr)
   );

   alu_muldiv #(.WIDTH(8)) dut8 (
      .CLK(clk), .nRST(nrst), .req_valid(rv8), .req_ready(ready8),
      .op(op8), .portA(a8), .portB(b8), .resp_valid(resp8),
      .result_lo(lo8), .result_hi(hi8), .overflow(ov8),
      .negative(ng8), .zero(zr8)
   );

   task automatic chk(input string nm, input logic [63:0] got,
                      input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   function automatic void model(input logic [4:0] o,
                                 input logic [31:0] a, b,
                                 output logic [31:0] rlo, rhi,
                                 output logic rov);
      longint s;
      logic [63:0] p;
      rlo = '0; rhi = '0; rov = 1'b0;
      case (o)
         5'h00: rlo = a << b[4:0];
         5'h01: rlo = a >> b[4:0];
         5'h02: begin
            s = longint'($signed(a)) + longint'($signed(b));
            rlo = a + b;
            rov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'h03: begin
            s = longint'($signed(a)) - longint'($signed(b));
            rlo = a - b;
            rov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
         end
         5'h04: rlo = a & b;
         5'h05: rlo = a | b;
         5'h06: rlo = a ^ b;
         5'h07: rlo = ~(a | b);
         5'h08: rlo = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         5'h09: rlo = (a < b) ? 32'd1 : 32'd0;
         5'h10: begin
            p = 64'(longint'($signed(a)) * longint'($signed(b)));
            {rhi, rlo} = p;
         end
         5'h11: begin
            p = {32'b0, a} * {32'b0, b};
            {rhi, rlo} = p;
         end
         5'h12: begin
            if (b == 0) begin
               rlo = '1; rhi = a;
            end else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
               rlo = a; rhi = 0; rov = 1'b1;
            end else begin
               rlo = 32'($signed(a) / $signed(b));
               rhi = 32'($signed(a) % $signed(b));
            end
         end
         5'h13: begin
            if (b == 0) begin
               rlo = '1; rhi = a;
            end else begin
               rlo = a / b; rhi = a % b;
            end
         end
         default: ;
      endcase
      if (!EN && o[4]) begin
         rlo = '0; rhi = '0; rov = 1'b0;
      end
   endfunction

   task automatic run(input string nm, input logic [4:0] o,
                      input logic [31:0] a, b,
                      input logic [31:0] elo, ehi, input logic eov);
      int lat, exp_lat;
      bit rdy_bad;
      if (!EN && o[4]) begin
         elo = '0; ehi = '0; eov = 1'b0;
      end
      exp_lat = (EN && is_md(o)) ? 33 : 1;
      @(negedge clk);
      rv = 1'b1; opv = o; pa = a; pb = b;
      @(posedge clk); #1;
      opv = 5'h03; pa = $urandom; pb = $urandom; rv = !resp;
      lat = 1; rdy_bad = 1'b0;
      while (!resp && lat < 200) begin
         if (ready) rdy_bad = 1'b1;
         @(posedge clk); #1;
         lat++;
      end
      rv = 1'b0;
      chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
      chk({nm, "_busy_ready"}, 64'(rdy_bad), 64'd0);
      chk({nm, "_lo"}, 64'(lo), 64'(elo));
      chk({nm, "_hi"}, 64'(hi), 64'(ehi));
      chk({nm, "_ovf"}, 64'(ov), 64'(eov));
      chk({nm, "_neg"}, 64'(ng), 64'(elo[31]));
      chk({nm, "_zero"}, 64'(zr), 64'(elo == 0));
      @(posedge clk); #1;
      chk({nm, "_strobe"}, 64'(resp), 64'd0);
      chk({nm, "_hold"}, {hi, lo}, {ehi, elo});
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'h0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   typedef struct {
      string       nm;
      logic [4:0]  o;
      logic [31:0] a, b, elo, ehi;
      logic        eov;
   } vec_t;

   vec_t vt[12];

   initial begin
      int lat;
      bit seen;
      logic [4:0]  ro;
      logic [31:0] ra, rb, mlo, mhi;
      logic        mov;

      vt[0]  = '{"add_ovf",  OPX_ADD,   32'h7FFFFFFF, 32'h1,
                 32'h80000000, 32'h0, 1'b1};
      vt[1]  = '{"mult_neg", OPX_MULT,  32'hFFFFFFFE, 32'h3,
                 32'hFFFFFFFA, 32'hFFFFFFFF, 1'b0};
      vt[2]  = '{"div_m7_2", OPX_DIV,   32'hFFFFFFF9, 32'h2,
                 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0};
      vt[3]  = '{"divu_z",   OPX_DIVU,  32'h7, 32'h0,
                 32'hFFFFFFFF, 32'h7, 1'b0};
      vt[4]  = '{"div_ovf",  OPX_DIV,   32'h80000000, 32'hFFFFFFFF,
                 32'h80000000, 32'h0, 1'b1};
      vt[5]  = '{"sub_ovf",  OPX_SUB,   32'h80000000, 32'h1,
                 32'h7FFFFFFF, 32'h0, 1'b1};
      vt[6]  = '{"slt",      OPX_SLT,   32'hFFFFFFFF, 32'h1,
                 32'h1, 32'h0, 1'b0};
      vt[7]  = '{"sltu",     OPX_SLTU,  32'hFFFFFFFF, 32'h1,
                 32'h0, 32'h0, 1'b0};
      vt[8]  = '{"sll31",    OPX_SLL,   32'h1, 32'h3F,
                 32'h80000000, 32'h0, 1'b0};
      vt[9]  = '{"nor",      OPX_NOR,   32'h0, 32'h0,
                 32'hFFFFFFFF, 32'h0, 1'b0};
      vt[10] = '{"multu_max", OPX_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF,
                 32'h00000001, 32'hFFFFFFFE, 1'b0};
      vt[11] = '{"div_7_m2", OPX_DIV,   32'h7, 32'hFFFFFFFE,
                 32'hFFFFFFFD, 32'h1, 1'b0};

      #1;
      chk("rst_resp", 64'(resp), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      chk("rst_lo_hi", {hi, lo}, 64'd0);
      chk("rst_flags", {61'd0, ov, ng, zr}, 64'd1);
      repeat (2) @(negedge clk);
      nrst = 1'b1;

      for (int i = 0; i < 12; i++)
         run(vt[i].nm, vt[i].o, vt[i].a, vt[i].b,
             vt[i].elo, vt[i].ehi, vt[i].eov);

      run("unlisted", 5'h0F, 32'h1234, 32'h5678, 32'h0, 32'h0, 1'b0);

      for (int i = 0; i < 40; i++) begin
         ro = 5'($urandom_range(0, 19));
         ra = pick();
         rb = pick();
         model(ro, ra, rb, mlo, mhi, mov);
         run($sformatf("rnd%0d_op%0h", i, ro), ro, ra, rb, mlo, mhi, mov);
      end

      @(negedge clk);
      rv = 1'b1; opv = OPX_MULTU; pa = 32'd3; pb = 32'd5;
      @(posedge clk); #1;
      rv = 1'b0;
      lat = 1;
      while (!resp && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("b2b_first_lat", 64'(lat), EN ? 64'd33 : 64'd1);
      chk("b2b_first_lo", 64'(lo), EN ? 64'd15 : 64'd0);
      @(negedge clk);
      chk("b2b_ready_done", 64'(ready), 64'd1);
      rv = 1'b1; opv = OPX_SUB; pa = 32'd10; pb = 32'd3;
      @(posedge clk); #1;
      rv = 1'b0;
      chk("b2b_second_resp", 64'(resp), 64'd1);
      chk("b2b_second_lo", 64'(lo), 64'd7);
      @(posedge clk); #1;
      chk("b2b_end", 64'(resp), 64'd0);

      @(negedge clk);
      rv8 = 1'b1; op8 = OPX_MULT; a8 = 8'hFE; b8 = 8'h03;
      @(posedge clk); #1;
      rv8 = 1'b0;
      lat = 1;
      while (!resp8 && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      chk("w8_mult_lat", 64'(lat), EN ? 64'd9 : 64'd1);
      chk("w8_mult_res", 64'({hi8, lo8}), EN ? 64'hFFFA : 64'h0);

      @(negedge clk);
      rv = 1'b1; opv = OPX_DIVU; pa = 32'd100; pb = 32'd7;
      @(posedge clk); #1;
      rv = 1'b0;
      repeat (9) @(posedge clk);
      #1 nrst = 1'b0;
      #1;
      chk("arst_resp", 64'(resp), 64'd0);
      chk("arst_ready", 64'(ready), 64'd1);
      chk("arst_lo_hi", {hi, lo}, 64'd0);
      chk("arst_flags", {61'd0, ov, ng, zr}, 64'd1);
      @(negedge clk);
      nrst = 1'b1;
      seen = 1'b0;
      repeat (60) begin
         @(posedge clk); #1;
         if (resp) seen = 1'b1;
      end
      chk("arst_no_resp", 64'(seen), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
